// File: rtl/fft_stage_sched.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT driving one pipelined butterfly.
// Issues one read pair per cycle and replays each pair BTFLY_LAT cycles later as the write-back.
module fft_stage_sched #(
    parameter int LOG2N     = 10,
    parameter int BTFLY_LAT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_u1_start,
    input  logic                         i_u1_hold,
    input  logic                         i_u1_btfly_valid,
    output logic                         o_u1_busy,
    output logic                         o_u1_done,
    output logic                         o_u1_err,
    output logic                         o_u1_issue,
    output logic [LOG2N-1:0]             o_rd_addr0,
    output logic [LOG2N-1:0]             o_rd_addr1,
    output logic [LOG2N-2:0]             o_tw_idx,
    output logic                         o_u1_wr_en,
    output logic [LOG2N-1:0]             o_wr_addr0,
    output logic [LOG2N-1:0]             o_wr_addr1,
    output logic [$clog2(LOG2N)-1:0]     o_stage
);

    localparam int SW = $clog2(LOG2N);
    localparam int DW = $clog2(BTFLY_LAT) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [LOG2N-2:0] k_q, k_d;
    logic [SW-1:0]    s_q, s_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic             issue_d;
    logic             start_acc;

    logic [LOG2N-1:0] span_c, mask_c, kk_c, a0_c, a1_c;
    logic [LOG2N-2:0] tw_c;

    logic             dl_issue [BTFLY_LAT];
    logic [LOG2N-1:0] dl_a0    [BTFLY_LAT];
    logic [LOG2N-1:0] dl_a1    [BTFLY_LAT];

    always_comb begin
        span_c = LOG2N'(1) << s_q;
        mask_c = span_c - LOG2N'(1);
        kk_c   = {1'b0, k_q};
        a0_c   = ((kk_c >> s_q) << (32'(s_q) + 1)) | (kk_c & mask_c);
        a1_c   = a0_c | span_c;
        tw_c   = (k_q & mask_c[LOG2N-2:0]) << (LOG2N - 1 - 32'(s_q));
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        s_d       = s_q;
        dcnt_d    = dcnt_q;
        issue_d   = 1'b0;
        start_acc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_u1_start) begin
                    state_d   = RUN;
                    k_d       = '0;
                    s_d       = '0;
                    start_acc = 1'b1;
                end
            end
            RUN: begin
                if (!i_u1_hold) begin
                    issue_d = 1'b1;
                    k_d     = k_q + 1'b1;
                    if (k_q == '1) begin
                        state_d = DRAIN;
                        dcnt_d  = '0;
                    end
                end
            end
            DRAIN: begin
                dcnt_d = dcnt_q + 1'b1;
                if (dcnt_q == DW'(BTFLY_LAT - 1)) begin
                    if (s_q == SW'(LOG2N - 1)) begin
                        state_d = DONE;
                    end else begin
                        s_d     = s_q + 1'b1;
                        k_d     = '0;
                        state_d = RUN;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            s_q        <= '0;
            dcnt_q     <= '0;
            o_u1_issue <= 1'b0;
            o_rd_addr0 <= '0;
            o_rd_addr1 <= '0;
            o_tw_idx   <= '0;
            o_u1_busy  <= 1'b0;
            o_u1_done  <= 1'b0;
            o_u1_err   <= 1'b0;
            for (int unsigned i = 0; i < BTFLY_LAT; i++) begin
                dl_issue[i] <= 1'b0;
                dl_a0[i]    <= '0;
                dl_a1[i]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            s_q        <= s_d;
            dcnt_q     <= dcnt_d;
            o_u1_issue <= issue_d;
            if (issue_d) begin
                o_rd_addr0 <= a0_c;
                o_rd_addr1 <= a1_c;
                o_tw_idx   <= tw_c;
            end
            o_u1_busy <= (state_q == RUN) || (state_q == DRAIN);
            o_u1_done <= (state_q == DONE);
            // The delayed issue bit is what is visible on o_u1_wr_en this cycle.
            if (start_acc)
                o_u1_err <= 1'b0;
            else if (dl_issue[BTFLY_LAT-1] != i_u1_btfly_valid)
                o_u1_err <= 1'b1;
            dl_issue[0] <= o_u1_issue;
            dl_a0[0]    <= o_rd_addr0;
            dl_a1[0]    <= o_rd_addr1;
            for (int unsigned i = 1; i < BTFLY_LAT; i++) begin
                dl_issue[i] <= dl_issue[i-1];
                dl_a0[i]    <= dl_a0[i-1];
                dl_a1[i]    <= dl_a1[i-1];
            end
        end
    end

    assign o_u1_wr_en = dl_issue[BTFLY_LAT-1];
    assign o_wr_addr0 = dl_a0[BTFLY_LAT-1];
    assign o_wr_addr1 = dl_a1[BTFLY_LAT-1];
    assign o_stage    = s_q;

endmodule

// File: tb/tb_fft_stage_sched.sv
// Directed bench for fft_stage_sched: an N=8 instance with cycle-exact tables and an N=1024 instance.
// Cycle n is the value visible just after the n-th rising edge following the start edge.
module tb_fft_stage_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start1, hold1, bv1;
    logic       busy1, done1, err1, issue1, wr1;
    logic [2:0] ra0_1, ra1_1, wa0_1, wa1_1;
    logic [1:0] tw1;
    logic [1:0] stage1;

    logic       start2, hold2, bv2;
    logic       busy2, done2, err2, issue2, wr2;
    logic [9:0] ra0_2, ra1_2, wa0_2, wa1_2;
    logic [8:0] tw2;
    logic [3:0] stage2;

    fft_stage_sched #(.LOG2N(3), .BTFLY_LAT(4)) dut1 (
        .clk(clk), .rst(rst), .i_u1_start(start1), .i_u1_hold(hold1),
        .i_u1_btfly_valid(bv1), .o_u1_busy(busy1), .o_u1_done(done1),
        .o_u1_err(err1), .o_u1_issue(issue1), .o_rd_addr0(ra0_1),
        .o_rd_addr1(ra1_1), .o_tw_idx(tw1), .o_u1_wr_en(wr1),
        .o_wr_addr0(wa0_1), .o_wr_addr1(wa1_1), .o_stage(stage1)
    );

    fft_stage_sched #(.LOG2N(10), .BTFLY_LAT(4)) dut2 (
        .clk(clk), .rst(rst), .i_u1_start(start2), .i_u1_hold(hold2),
        .i_u1_btfly_valid(bv2), .o_u1_busy(busy2), .o_u1_done(done2),
        .o_u1_err(err2), .o_u1_issue(issue2), .o_rd_addr0(ra0_2),
        .o_rd_addr1(ra1_2), .o_tw_idx(tw2), .o_u1_wr_en(wr2),
        .o_wr_addr0(wa0_2), .o_wr_addr1(wa1_2), .o_stage(stage2)
    );

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-derived read pairs and twiddles for N=8, stages 0..2.
    int unsigned ea0 [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int unsigned ea1 [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int unsigned etw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};
    int unsigned ic  [12];

    task automatic check_idle1(input string tag);
        check({tag, " issue"}, 32'(issue1), 0);
        check({tag, " wr_en"}, 32'(wr1), 0);
        check({tag, " busy"},  32'(busy1), 0);
        check({tag, " done"},  32'(done1), 0);
        check({tag, " err"},   32'(err1), 0);
        check({tag, " rd0"},   32'(ra0_1), 0);
        check({tag, " rd1"},   32'(ra1_1), 0);
        check({tag, " tw"},    32'(tw1), 0);
        check({tag, " wa0"},   32'(wa0_1), 0);
        check({tag, " wa1"},   32'(wa1_1), 0);
        check({tag, " stage"}, 32'(stage1), 0);
    endtask

    // One N=8 transform against the issue schedule in ic[].
    task automatic run_sched(input string name, input int unsigned done_c,
                             input bit hold_en, input int unsigned hold_lo, input int unsigned hold_hi,
                             input int unsigned glitch, input int unsigned abort_at,
                             input int unsigned ign_start);
        int ji, jw, last_j;
        string t;
        last_j = -1;
        start1 = 1'b1;
        hold1  = hold_en && (hold_lo == 0);
        bv1    = 1'b0;
        tick();
        start1 = 1'b0;
        check({name, " c0 busy"}, 32'(busy1), 0);
        for (int unsigned n = 1; n <= done_c + 1; n++) begin
            hold1  = hold_en && (n >= hold_lo) && (n <= hold_hi);
            start1 = (n == ign_start);
            rst    = (n == abort_at);
            tick();
            t = $sformatf("%s c%0d", name, n);
            if (abort_at != 0 && n == abort_at) begin
                check_idle1({t, " after rst"});
                break;
            end
            ji = -1;
            jw = -1;
            for (int j = 0; j < 12; j++) begin
                if (ic[j] == n) ji = j;
                if (ic[j] + 4 == n) jw = j;
            end
            check({t, " issue"}, 32'(issue1), 32'(ji >= 0));
            if (ji >= 0) begin
                last_j = ji;
                check({t, " stage"}, 32'(stage1), 32'(ji / 4));
            end
            if (last_j >= 0) begin
                check({t, " rd0"}, 32'(ra0_1), ea0[last_j]);
                check({t, " rd1"}, 32'(ra1_1), ea1[last_j]);
                check({t, " tw"},  32'(tw1),   etw[last_j]);
            end
            check({t, " wr_en"}, 32'(wr1), 32'(jw >= 0));
            if (jw >= 0) begin
                check({t, " wa0"}, 32'(wa0_1), ea0[jw]);
                check({t, " wa1"}, 32'(wa1_1), ea1[jw]);
            end
            check({t, " busy"}, 32'(busy1), 32'(n < done_c));
            check({t, " done"}, 32'(done1), 32'(n == done_c));
            check({t, " err"},  32'(err1),  32'(glitch != 0 && n > glitch));
            bv1 = (jw >= 0) && (n != glitch);
        end
        rst    = 1'b0;
        start1 = 1'b0;
        hold1  = 1'b0;
        bv1    = 1'b0;
    endtask

    int unsigned n_iss2, n_wr2, done_n2, m, st, off;

    initial begin
        rst = 1'b1; start1 = 1'b0; hold1 = 1'b0; bv1 = 1'b0;
        start2 = 1'b0; hold2 = 1'b0; bv2 = 1'b0;
        tick(); tick(); tick();
        check_idle1("reset");
        check("reset dut2 busy", 32'(busy2), 0);
        check("reset dut2 wr_en", 32'(wr2), 0);
        rst = 1'b0;
        tick();

        // Plain run; a start pulse mid-run must be ignored.
        ic = '{1, 2, 3, 4,  9, 10, 11, 12,  17, 18, 19, 20};
        run_sched("plain", 25, 1'b0, 0, 0, 0, 0, 3);
        tick();

        ic = '{1, 4, 5, 6,  11, 12, 13, 14,  19, 20, 21, 22};
        run_sched("hold", 27, 1'b1, 2, 3, 0, 0, 0);
        tick();

        // Hold together with start only delays the first issue.
        ic = '{2, 3, 4, 5,  10, 11, 12, 13,  18, 19, 20, 21};
        run_sched("hold_start", 26, 1'b1, 0, 1, 0, 0, 0);
        tick();

        ic = '{1, 2, 3, 4,  9, 10, 11, 12,  17, 18, 19, 20};
        run_sched("glitch", 25, 1'b0, 0, 0, 6, 0, 0);
        tick();
        run_sched("err_clear", 25, 1'b0, 0, 0, 0, 0, 0);
        tick();

        // Reset lands in stage 1 RUN; the restart follows on the next edge.
        run_sched("abort", 25, 1'b0, 0, 0, 0, 11, 0);
        run_sched("restart", 25, 1'b0, 0, 0, 0, 0, 0);
        tick();

        // N=1024 transform.
        n_iss2 = 0; n_wr2 = 0; done_n2 = 0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int unsigned n = 1; n <= 6000; n++) begin
            tick();
            if (issue2) n_iss2++;
            if (wr2) n_wr2++;
            if (n == 5156) begin
                check("n1024 last issue", 32'(issue2), 1);
                check("n1024 last rd0", 32'(ra0_2), 511);
                check("n1024 last rd1", 32'(ra1_2), 1023);
                check("n1024 last tw", 32'(tw2), 511);
                check("n1024 last stage", 32'(stage2), 9);
            end
            if (done2) begin
                done_n2 = n;
                break;
            end
            bv2 = 1'b0;
            if (n >= 5) begin
                m   = n - 5;
                st  = m / 516;
                off = m % 516;
                bv2 = (st < 10) && (off < 512);
            end
        end
        bv2 = 1'b0;
        check("n1024 done cycle", done_n2, 5161);
        check("n1024 issues", n_iss2, 5120);
        check("n1024 writes", n_wr2, 5120);
        check("n1024 err", 32'(err2), 0);
        check("n1024 busy at done", 32'(busy2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
